// File: rtl/aes_sched.sv
// aes_sched
// Arbitrates two requesters onto a single AES core. It accepts one operation
// at a time using round-robin priority. It loads the key only when it differs
// from the last key the core finished expanding, then loads the plaintext and
// returns the core result to the requester that was granted. A watchdog bounds
// each wait on the core. When the watchdog expires, the operation completes
// with rsp_err=1 and a zero result.
//
// Parameters
//   TMO          watchdog limit in clk cycles per kdone/done wait (2..1023)
//   KCACHE       1 = skip the key load when the granted key is already expanded
// Ports
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester request, accepted when req_ready is also 1
//   req_ready    one-cycle accept pulse to the winner
//   r0_key/text  requester 0 key and plaintext
//   r1_key/text  requester 1 key and plaintext
//   rsp_valid    per-requester result available (one-hot or zero)
//   rsp_ready    per-requester result consume
//   rsp_text     result data, zero on watchdog abort
//   rsp_err      result was aborted by the watchdog
//   aes_kld      key-load strobe to the core, with aes_key
//   aes_ld       data-load strobe to the core, with aes_text_in
//   aes_kdone    core key expansion complete
//   aes_done     core encryption complete, aes_text_out valid
module aes_sched #(
    parameter int TMO    = 64,
    parameter int KCACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] r0_key,
    input  logic [127:0] r1_key,
    input  logic [127:0] r0_text,
    input  logic [127:0] r1_text,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [127:0] rsp_text,
    output logic         rsp_err,
    output logic         aes_kld,
    output logic         aes_ld,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    input  logic         aes_kdone,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out
);

    typedef enum logic [2:0] {IDLE, ARB, KLOAD, KWAIT, DLOAD, DWAIT, RESP} state_t;

    // The watchdog counts from 0 in the first wait cycle. It therefore expires
    // in the TMO-th cycle of a wait.
    localparam logic [9:0] WDOG_LAST = 10'(TMO - 1);

    state_t       state;
    state_t       state_nxt;
    logic         prio;
    logic         grant;
    logic         winner;
    logic         cache_valid;
    logic         cache_hit;
    logic         wdog_expired;
    logic         err_q;
    logic [127:0] key_q;
    logic [127:0] text_q;
    logic [127:0] result_q;
    logic [127:0] cache_key;
    logic [127:0] winner_key;
    logic [127:0] winner_text;
    logic [9:0]   wdog;

    // prio names the requester that wins a tie. A lone valid requester always wins.
    assign winner       = (req_valid == 2'b11) ? prio : ~req_valid[0];
    assign winner_key   = winner ? r1_key : r0_key;
    assign winner_text  = winner ? r1_text : r0_text;
    assign cache_hit    = (KCACHE != 0) && cache_valid && (winner_key == cache_key);
    assign wdog_expired = (wdog == WDOG_LAST);

    assign aes_key     = key_q;
    assign aes_text_in = text_q;
    assign rsp_text    = result_q;
    assign rsp_err     = err_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the strobes. Done events are tested before the
    // watchdog, so a completion in the expiry cycle counts as a success.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        aes_kld   = 1'b0;
        aes_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (!(|req_valid)) begin
                    state_nxt = IDLE;
                end else begin
                    req_ready = winner ? 2'b10 : 2'b01;
                    state_nxt = cache_hit ? DLOAD : KLOAD;
                end
            end
            KLOAD: begin
                aes_kld   = 1'b1;
                state_nxt = KWAIT;
            end
            KWAIT: begin
                if (aes_kdone) begin
                    state_nxt = DLOAD;
                end else if (wdog_expired) begin
                    state_nxt = RESP;
                end
            end
            DLOAD: begin
                aes_ld    = 1'b1;
                state_nxt = DWAIT;
            end
            DWAIT: begin
                if (aes_done || wdog_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = grant ? 2'b10 : 2'b01;
                if (rsp_ready[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant capture, the key cache, the watchdog and the result register.
    // KLOAD and DLOAD always precede the wait states, so clearing the watchdog
    // there clears it on entry to every wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio        <= 1'b0;
            grant       <= 1'b0;
            key_q       <= '0;
            text_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cache_key   <= '0;
            cache_valid <= 1'b0;
            wdog        <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (|req_valid) begin
                        grant  <= winner;
                        prio   <= ~winner;
                        key_q  <= winner_key;
                        text_q <= winner_text;
                        err_q  <= 1'b0;
                    end
                end
                KLOAD, DLOAD: begin
                    wdog <= '0;
                end
                KWAIT: begin
                    wdog <= wdog + 10'd1;
                    if (aes_kdone) begin
                        cache_key   <= key_q;
                        cache_valid <= 1'b1;
                    end else if (wdog_expired) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        cache_valid <= 1'b0;
                    end
                end
                DWAIT: begin
                    wdog <= wdog + 10'd1;
                    if (aes_done) begin
                        result_q <= aes_text_out;
                        err_q    <= 1'b0;
                    end else if (wdog_expired) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        cache_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched
// Self-checking bench for aes_sched. An emulated AES core answers the key and
// data strobes after a programmable number of cycles. A delay of 0 means the
// core never answers. A behavioural scoreboard predicts each grant and its
// response. The directed tests pin literal values and latencies.
module tb_aes_sched;

    localparam int           TMO_TB    = 8;
    localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_TEXT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_A       = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] T_A       = 128'hdeadbeef_00000001_cafef00d_00000002;
    localparam logic [127:0] K_B       = 128'h99999999_88888888_77777777_66666666;
    localparam logic [127:0] T_B       = 128'h0badf00d_12345678_9abcdef0_0fedcba9;
    localparam logic [127:0] K_C       = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] T_C       = 128'h00000000_ffffffff_55555555_aaaaaaaa;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] r0_key;
    logic [127:0] r1_key;
    logic [127:0] r0_text;
    logic [127:0] r1_text;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_text;
    logic         rsp_err;
    logic         aes_kld;
    logic         aes_ld;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_kdone;
    logic         aes_done;
    logic [127:0] aes_text_out;

    aes_sched #(.TMO(TMO_TB), .KCACHE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .r0_key(r0_key), .r1_key(r1_key), .r0_text(r0_text), .r1_text(r1_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_err(rsp_err),
        .aes_kld(aes_kld), .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_kdone(aes_kdone), .aes_done(aes_done), .aes_text_out(aes_text_out)
    );

    typedef struct {
        logic         id;
        logic [127:0] text;
        logic         err;
        int           exp_kld;
        int           exp_ld;
        int           kld_base;
        int           ld_base;
    } op_t;

    op_t          op_q[$];
    op_t          head;
    op_t          new_op;
    logic         grant_log[$];

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           kld_count = 0;
    int           ld_count = 0;
    int           ld_cyc = 0;
    int           done_cyc = 0;
    int           kd_delay = 2;
    int           d_delay = 3;
    int           kd_timer = 0;
    int           d_timer = 0;
    int           grant_count = 0;
    int           grant_cyc = 0;
    int           rsp_count = 0;
    int           rsp_first_cyc = 0;

    logic         m_prio = 1'b0;
    logic         m_cache_valid = 1'b0;
    logic [127:0] m_cache_key = '0;
    logic         m_w;
    logic         m_hit;
    logic         m_key_ok;
    logic         m_data_ok;
    logic [127:0] m_key;
    logic [127:0] m_text;
    logic [1:0]   m_exp_ready;
    logic         head_seen = 1'b0;
    logic         last_id = 1'b0;
    logic         last_err = 1'b0;
    logic [127:0] last_text = '0;

    // The emulated core returns the real FIPS-197 ciphertext for the reference
    // vector. For any other key/text pair it returns an arbitrary mix of the two.
    function automatic logic [127:0] core_result(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_TEXT) begin
            return FIPS_CT;
        end
        return k ^ {t[63:0], t[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #1;
        check_output("reset_ctrl", 128'({req_ready, rsp_valid, rsp_err, aes_kld, aes_ld}), 128'(0));
        check_output("reset_rsp_text", rsp_text, '0);
        check_output("reset_aes_key", aes_key, '0);
        check_output("reset_aes_text_in", aes_text_in, '0);
        step();
        step();
        rst = 1'b1;
    endtask

    // Raise one requester's valid and hold it until the scoreboard sees the grant.
    task automatic apply_stimulus(input int r, input logic [127:0] key, input logic [127:0] text);
        int base;
        int cnt;
        base = grant_count;
        cnt  = 0;
        if (r == 0) begin
            r0_key  = key;
            r0_text = text;
        end else begin
            r1_key  = key;
            r1_text = text;
        end
        req_valid[r] = 1'b1;
        while (grant_count == base && cnt < 100) begin
            step();
            cnt++;
        end
        if (grant_count == base) begin
            check_output("grant_wait", 128'(grant_count - base), 128'(1));
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp_until(input int target);
        int cnt;
        cnt = 0;
        while (rsp_count < target && cnt < 300) begin
            step();
            cnt++;
        end
        if (rsp_count < target) begin
            check_output("rsp_wait", 128'(rsp_count), 128'(target));
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Emulated AES core: it answers kdone/done a programmed number of cycles after each strobe.
    initial begin
        aes_kdone    = 1'b0;
        aes_done     = 1'b0;
        aes_text_out = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            aes_kdone    = 1'b0;
            aes_done     = 1'b0;
            aes_text_out = '0;
            if (!rst) begin
                kd_timer = 0;
                d_timer  = 0;
            end else begin
                if (kd_timer > 0) begin
                    kd_timer--;
                    if (kd_timer == 0) aes_kdone = 1'b1;
                end
                if (d_timer > 0) begin
                    d_timer--;
                    if (d_timer == 0) begin
                        aes_done     = 1'b1;
                        aes_text_out = core_result(aes_key, aes_text_in);
                        done_cyc     = cyc;
                    end
                end
                if (aes_kld) begin
                    kld_count++;
                    kd_timer = kd_delay;
                end
                if (aes_ld) begin
                    ld_count++;
                    ld_cyc  = cyc;
                    d_timer = d_delay;
                end
            end
        end
    end

    // Scoreboard: predicts each grant from round-robin and the requests seen,
    // and derives the expected response from the cache state and the core delays.
    // It compares every cycle on which a grant or a response is visible.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                op_q.delete();
                m_prio        = 1'b0;
                m_cache_valid = 1'b0;
                head_seen     = 1'b0;
            end else begin
                if (req_ready != 2'b00) begin
                    m_w         = (req_valid == 2'b11) ? m_prio : req_valid[1];
                    m_exp_ready = (req_valid == 2'b00) ? 2'b00 : (m_w ? 2'b10 : 2'b01);
                    check_output("req_ready", 128'(req_ready), 128'(m_exp_ready));
                    if (req_valid != 2'b00) begin
                        m_key     = m_w ? r1_key : r0_key;
                        m_text    = m_w ? r1_text : r0_text;
                        m_hit     = m_cache_valid && (m_key == m_cache_key);
                        m_key_ok  = m_hit || (kd_delay >= 1 && kd_delay <= TMO_TB);
                        m_data_ok = m_key_ok && d_delay >= 1 && d_delay <= TMO_TB;
                        if (!m_hit && m_key_ok) begin
                            m_cache_valid = 1'b1;
                            m_cache_key   = m_key;
                        end
                        if (!m_data_ok) m_cache_valid = 1'b0;
                        new_op.id       = m_w;
                        new_op.text     = m_data_ok ? core_result(m_key, m_text) : '0;
                        new_op.err      = !m_data_ok;
                        new_op.exp_kld  = m_hit ? 0 : 1;
                        new_op.exp_ld   = m_key_ok ? 1 : 0;
                        new_op.kld_base = kld_count;
                        new_op.ld_base  = ld_count;
                        op_q.push_back(new_op);
                        grant_log.push_back(m_w);
                        grant_count++;
                        grant_cyc = cyc;
                        m_prio    = !m_w;
                    end
                end
                if (rsp_valid != 2'b00) begin
                    if (op_q.size() == 0) begin
                        check_output("rsp_unexpected", 128'(rsp_valid), 128'(0));
                    end else begin
                        head = op_q[0];
                        if (!head_seen) begin
                            head_seen     = 1'b1;
                            rsp_first_cyc = cyc;
                        end
                        check_output("rsp_valid", 128'(rsp_valid), head.id ? 128'(2) : 128'(1));
                        check_output("rsp_text", rsp_text, head.text);
                        check_output("rsp_err", 128'(rsp_err), 128'(head.err));
                        if ((rsp_valid & rsp_ready) != 2'b00) begin
                            check_output("kld_pulses", 128'(kld_count - head.kld_base), 128'(head.exp_kld));
                            check_output("ld_pulses", 128'(ld_count - head.ld_base), 128'(head.exp_ld));
                            last_id   = head.id;
                            last_err  = rsp_err;
                            last_text = rsp_text;
                            rsp_count++;
                            head_seen = 1'b0;
                            void'(op_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int           rb;
        int           kb;
        int           lb;
        int           gb;
        int           cnt;
        logic [2:0]   g3;

        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        r0_key    = '0;
        r1_key    = '0;
        r0_text   = '0;
        r1_text   = '0;
        #2;
        $display("[TB] reset values");
        reset_dut();

        $display("[TB] FIPS-197 vector with rsp_ready on the other requester first");
        kd_delay  = 2;
        d_delay   = 3;
        rsp_ready = 2'b10;
        rb = rsp_count; kb = kld_count; lb = ld_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        cnt = 0;
        while (rsp_valid == 2'b00 && cnt < 60) begin
            step();
            cnt++;
        end
        repeat (3) step();
        check_output("rsp_held", 128'(rsp_valid), 128'(2'b01));
        rsp_ready = 2'b11;
        wait_rsp_until(rb + 1);
        check_output("fips_kld", 128'(kld_count - kb), 128'(1));
        check_output("fips_ld", 128'(ld_count - lb), 128'(1));
        check_output("fips_id", 128'(last_id), 128'(0));
        check_output("fips_text", last_text, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_output("fips_err", 128'(last_err), 128'(0));
        check_output("fips_latency", 128'(rsp_first_cyc), 128'(done_cyc + 1));

        $display("[TB] cache hit");
        rb = rsp_count; kb = kld_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        wait_rsp_until(rb + 1);
        check_output("hit_kld", 128'(kld_count - kb), 128'(0));
        check_output("hit_ld_cycle", 128'(ld_cyc), 128'(grant_cyc + 1));
        check_output("hit_text", last_text, FIPS_CT);

        $display("[TB] withdrawal before grant");
        gb = grant_count; kb = kld_count;
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        repeat (6) step();
        check_output("withdraw_grants", 128'(grant_count), 128'(gb));
        check_output("withdraw_kld", 128'(kld_count), 128'(kb));

        $display("[TB] contention");
        reset_dut();
        r0_key = K_A; r0_text = T_A; r1_key = K_B; r1_text = T_B;
        gb = grant_count; rb = rsp_count;
        req_valid = 2'b11;
        cnt = 0;
        while (grant_count < gb + 3 && cnt < 300) begin
            step();
            cnt++;
        end
        req_valid = 2'b00;
        wait_rsp_until(rb + 3);
        check_output("contention_grants", 128'(grant_count - gb), 128'(3));
        g3 = {grant_log[grant_log.size() - 3], grant_log[grant_log.size() - 2], grant_log[grant_log.size() - 1]};
        check_output("contention_order", 128'(g3), 128'(3'b010));

        $display("[TB] data timeout and key reload");
        d_delay = 0;
        rb = rsp_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        wait_rsp_until(rb + 1);
        check_output("tmo_err", 128'(last_err), 128'(1));
        check_output("tmo_text", last_text, '0);
        check_output("tmo_latency", 128'(rsp_first_cyc), 128'(ld_cyc + TMO_TB + 1));
        d_delay = 3;
        rb = rsp_count; kb = kld_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        wait_rsp_until(rb + 1);
        check_output("reload_kld", 128'(kld_count - kb), 128'(1));
        check_output("reload_text", last_text, FIPS_CT);

        $display("[TB] done coincident with watchdog expiry");
        d_delay = TMO_TB;
        rb = rsp_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        wait_rsp_until(rb + 1);
        check_output("simul_err", 128'(last_err), 128'(0));
        check_output("simul_text", last_text, FIPS_CT);
        check_output("simul_done_cycle", 128'(done_cyc), 128'(ld_cyc + TMO_TB));
        check_output("simul_latency", 128'(rsp_first_cyc), 128'(done_cyc + 1));

        $display("[TB] done one cycle after expiry");
        d_delay = TMO_TB + 1;
        rb = rsp_count;
        apply_stimulus(0, FIPS_KEY, FIPS_TEXT);
        wait_rsp_until(rb + 1);
        check_output("late_err", 128'(last_err), 128'(1));
        check_output("late_text", last_text, '0);

        $display("[TB] reset in DWAIT");
        d_delay = 3;
        rb = rsp_count;
        apply_stimulus(1, K_C, T_C);
        wait_rsp_until(rb + 1);
        d_delay = 0;
        lb = ld_count;
        apply_stimulus(1, K_C, T_C);
        cnt = 0;
        while (ld_count == lb && cnt < 60) begin
            step();
            cnt++;
        end
        step();
        step();
        reset_dut();
        kb = kld_count; lb = ld_count; rb = rsp_count;
        repeat (12) step();
        check_output("post_reset_kld", 128'(kld_count), 128'(kb));
        check_output("post_reset_ld", 128'(ld_count), 128'(lb));
        check_output("post_reset_rsp", 128'(rsp_count), 128'(rb));
        d_delay = 3;
        apply_stimulus(1, K_C, T_C);
        wait_rsp_until(rb + 1);
        check_output("post_reset_reload", 128'(kld_count - kb), 128'(1));
        check_output("post_reset_text", last_text, core_result(K_C, T_C));
        check_output("post_reset_id", 128'(last_id), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
